c7b_rd_arb: RTL and testbench

Read-channel arbiter that shares the single AXI AR/R channel between the instruction cache unit (line refills and single-beat fetches) and the LSU (uncached 64-bit loads). Sits between `c7bicu`/LSU and the AXI read master port, replacing the read-side logic inside the BIU. It keeps at most one read transaction outstanding, picks requesters round-robin, and routes returning beats to the owner of the current transaction.

---
 rtl/c7b_rd_arb_pkg.sv | 21 ++
 rtl/c7b_rr_arb2.sv | 34 +++
 rtl/c7b_rd_arb.sv | 178 +++++++++++++++++
 tb/tb_c7b_rd_arb.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c7b_rd_arb_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
package c7b_rd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } rd_state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;

    localparam logic [3:0] ICU_ID_DEF        = 4'h0;
    localparam logic [3:0] LSU_ID_DEF        = 4'h1;
    localparam logic [7:0] LINE_BEATS_M1_DEF = 8'd3;

    // Requester bit positions in the arbiter request/grant vectors
    localparam int unsigned REQ_ICU = 0;
    localparam int unsigned REQ_LSU = 1;

endpackage

// File: rtl/c7b_rr_arb2.sv
// Two-requester round-robin grant; pointer advances only when a grant is accepted.
module c7b_rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // Index of the requester granted last; reset to ICU so LSU wins the first tie
    logic last_q, last_d;

    // Grant: single requester wins outright, a tie goes to the one not granted last
    always_comb begin
        gnt_o  = req_i;
        last_d = last_q;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end
        if (accept_i && (|req_i)) begin
            last_d = gnt_o[1];
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/c7b_rd_arb.sv
// Shares the AXI AR/R channel between ICU and LSU with one transaction outstanding.
module c7b_rd_arb
    import c7b_rd_arb_pkg::*;
#(
    parameter logic [3:0] ICU_ID        = ICU_ID_DEF,
    parameter logic [3:0] LSU_ID        = LSU_ID_DEF,
    parameter logic [7:0] LINE_BEATS_M1 = LINE_BEATS_M1_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    // ICU side
    input  logic        icu_biu_req,
    input  logic [28:0] icu_biu_addr,
    input  logic        icu_biu_single,
    output logic        biu_icu_ack,
    output logic        biu_icu_data_valid,
    output logic        biu_icu_data_last,
    output logic [63:0] biu_icu_data,
    output logic        biu_icu_fault,
    // LSU side
    input  logic        lsu_biu_rd_req,
    input  logic [31:0] lsu_biu_rd_addr,
    output logic        biu_lsu_rd_ack,
    output logic        biu_lsu_data_valid,
    output logic [63:0] biu_lsu_data,
    // AXI AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // AXI R channel
    input  logic [3:0]  rid,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rd_busy
);

    rd_state_e   state_q, state_d;
    logic        owner_lsu_q, owner_lsu_d;
    logic [3:0]  arid_q, arid_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [1:0]  arburst_q, arburst_d;
    logic [7:0]  beat_q, beat_d;
    logic        len_err_q, len_err_d;

    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        arb_accept;
    logic        unused_ok;

    assign req[REQ_ICU] = icu_biu_req;
    assign req[REQ_LSU] = lsu_biu_rd_req;

    c7b_rr_arb2 u_rr (
        .clk      (clk),
        .resetn   (resetn),
        .req_i    (req),
        .accept_i (arb_accept),
        .gnt_o    (gnt)
    );

    // FSM next state, AR field capture and beat-count checking
    always_comb begin
        state_d     = state_q;
        owner_lsu_d = owner_lsu_q;
        arid_d      = arid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arburst_d   = arburst_q;
        beat_d      = beat_q;
        len_err_d   = len_err_q;
        arb_accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    arb_accept = 1'b1;
                    state_d    = ST_AR;
                    beat_d     = '0;
                    arburst_d  = AXI_BURST_INCR;
                    if (gnt[REQ_LSU]) begin
                        owner_lsu_d = 1'b1;
                        arid_d      = LSU_ID;
                        araddr_d    = {lsu_biu_rd_addr[31:3], 3'b000};
                        arlen_d     = '0;
                    end else begin
                        owner_lsu_d = 1'b0;
                        arid_d      = ICU_ID;
                        if (icu_biu_single) begin
                            araddr_d = {icu_biu_addr, 3'b000};
                            arlen_d  = '0;
                        end else begin
                            araddr_d = {icu_biu_addr[28:2], 5'b00000};
                            arlen_d  = LINE_BEATS_M1;
                        end
                    end
                end
            end
            ST_AR: begin
                if (arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    beat_d = beat_q + 8'd1;
                    // Last beat expected once the count reaches arlen; overruns count as mismatches too
                    if (rlast != (beat_q >= arlen_q)) begin
                        len_err_d = 1'b1;
                    end
                    if (rlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and AR field registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            owner_lsu_q <= 1'b0;
            arid_q      <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arburst_q   <= '0;
            beat_q      <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_lsu_q <= owner_lsu_d;
            arid_q      <= arid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arburst_q   <= arburst_d;
            beat_q      <= beat_d;
            len_err_q   <= len_err_d;
        end
    end

    assign arvalid = (state_q == ST_AR);
    assign rready  = (state_q == ST_R);
    assign rd_busy = (state_q != ST_IDLE);

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = arlen_q;
    assign arburst = arburst_q;
    assign arsize  = AXI_SIZE_8B;
    assign arlock  = 1'b0;
    assign arcache = '0;
    assign arprot  = '0;

    assign biu_icu_ack    = arvalid & arready & ~owner_lsu_q;
    assign biu_lsu_rd_ack = arvalid & arready &  owner_lsu_q;

    assign biu_icu_data_valid = rvalid & rready & ~owner_lsu_q;
    assign biu_lsu_data_valid = rvalid & rready &  owner_lsu_q;
    assign biu_icu_data_last  = rlast;
    assign biu_icu_fault      = |rresp;
    assign biu_icu_data       = rdata;
    assign biu_lsu_data       = rdata;

    // rid is not needed for routing; len_err is a simulation-visible sticky flag
    assign unused_ok = ^{rid, lsu_biu_rd_addr[2:0], len_err_q};

endmodule

// File: tb/tb_c7b_rd_arb.sv
// Scoreboard bench for c7b_rd_arb: AR and R expectations queued at stimulus time.
module tb_c7b_rd_arb;
    import c7b_rd_arb_pkg::*;

    logic        clk;
    logic        resetn;
    logic        icu_biu_req;
    logic [28:0] icu_biu_addr;
    logic        icu_biu_single;
    logic        biu_icu_ack;
    logic        biu_icu_data_valid;
    logic        biu_icu_data_last;
    logic [63:0] biu_icu_data;
    logic        biu_icu_fault;
    logic        lsu_biu_rd_req;
    logic [31:0] lsu_biu_rd_addr;
    logic        biu_lsu_rd_ack;
    logic        biu_lsu_data_valid;
    logic [63:0] biu_lsu_data;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        rd_busy;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_exp_t;

    typedef struct {
        bit          lsu;
        logic [63:0] data;
        logic        last;
        logic        fault;
    } beat_exp_t;

    ar_exp_t   ar_q[$];
    beat_exp_t beat_q[$];

    int n_chk = 0;
    int n_err = 0;

    c7b_rd_arb #(
        .ICU_ID        (4'h0),
        .LSU_ID        (4'h1),
        .LINE_BEATS_M1 (8'd3)
    ) dut (
        .clk                (clk),
        .resetn             (resetn),
        .icu_biu_req        (icu_biu_req),
        .icu_biu_addr       (icu_biu_addr),
        .icu_biu_single     (icu_biu_single),
        .biu_icu_ack        (biu_icu_ack),
        .biu_icu_data_valid (biu_icu_data_valid),
        .biu_icu_data_last  (biu_icu_data_last),
        .biu_icu_data       (biu_icu_data),
        .biu_icu_fault      (biu_icu_fault),
        .lsu_biu_rd_req     (lsu_biu_rd_req),
        .lsu_biu_rd_addr    (lsu_biu_rd_addr),
        .biu_lsu_rd_ack     (biu_lsu_rd_ack),
        .biu_lsu_data_valid (biu_lsu_data_valid),
        .biu_lsu_data       (biu_lsu_data),
        .arid               (arid),
        .araddr             (araddr),
        .arlen              (arlen),
        .arsize             (arsize),
        .arburst            (arburst),
        .arlock             (arlock),
        .arcache            (arcache),
        .arprot             (arprot),
        .arvalid            (arvalid),
        .arready            (arready),
        .rid                (rid),
        .rdata              (rdata),
        .rresp              (rresp),
        .rlast              (rlast),
        .rvalid             (rvalid),
        .rready             (rready),
        .rd_busy            (rd_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        ar_exp_t e;
        e.id   = id;
        e.addr = addr;
        e.len  = len;
        ar_q.push_back(e);
    endtask

    task automatic check_reset_vals();
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_icu_ack", biu_icu_ack, 0);
        chk("rst_lsu_ack", biu_lsu_rd_ack, 0);
        chk("rst_icu_valid", biu_icu_data_valid, 0);
        chk("rst_lsu_valid", biu_lsu_data_valid, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_arid", arid, 0);
        chk("rst_arburst", arburst, 0);
        chk("rst_busy", rd_busy, 0);
    endtask

    // Wait for arvalid, hold arready low for wait_cyc cycles, then handshake and drop the owner's req
    task automatic ar_accept(input int wait_cyc);
        logic [3:0] id;
        int n = 0;
        while (!arvalid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!arvalid) begin
            chk("ar_timeout", arvalid, 1);
            return;
        end
        repeat (wait_cyc) begin
            @(posedge clk); #1;
        end
        arready = 1'b1;
        id = arid;
        @(posedge clk); #1;
        arready = 1'b0;
        if (id == 4'h1) lsu_biu_rd_req = 1'b0;
        else            icu_biu_req    = 1'b0;
    endtask

    // Drive n beats; rlast asserted on beat index last_at
    task automatic r_beats(input bit lsu, input int n, input logic [63:0] base,
                           input logic [1:0] resp, input int last_at);
        beat_exp_t e;
        for (int i = 0; i < n; i++) begin
            rvalid = 1'b1;
            rdata  = base + 64'(i);
            rlast  = (i == last_at);
            rresp  = resp;
            e.lsu   = lsu;
            e.data  = rdata;
            e.last  = rlast;
            e.fault = |resp;
            beat_q.push_back(e);
            @(posedge clk); #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    // Monitor: compare AR handshakes and consumed beats against the scoreboard
    always @(negedge clk) begin
        if (resetn) begin
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    chk("ar_unexpected", {arvalid, arready}, 0);
                end else begin
                    ar_exp_t e;
                    e = ar_q.pop_front();
                    chk("arid", arid, e.id);
                    chk("araddr", araddr, e.addr);
                    chk("arlen", arlen, e.len);
                    chk("arsize", arsize, 3);
                    chk("arburst", arburst, 1);
                    chk("lsu_ack", biu_lsu_rd_ack, (e.id == 4'h1));
                    chk("icu_ack", biu_icu_ack, (e.id == 4'h0));
                end
            end
            if (rvalid && rready) begin
                if (beat_q.size() == 0) begin
                    chk("beat_unexpected", {rvalid, rready}, 0);
                end else begin
                    beat_exp_t b;
                    b = beat_q.pop_front();
                    chk("icu_valid", biu_icu_data_valid, !b.lsu);
                    chk("lsu_valid", biu_lsu_data_valid, b.lsu);
                    if (b.lsu) begin
                        chk("lsu_data", biu_lsu_data, b.data);
                    end else begin
                        chk("icu_data", biu_icu_data, b.data);
                        chk("icu_last", biu_icu_data_last, b.last);
                        chk("icu_fault", biu_icu_fault, b.fault);
                    end
                end
            end else if (rvalid) begin
                chk("valid_gated", {biu_icu_data_valid, biu_lsu_data_valid}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        icu_biu_req = 1'b0; icu_biu_addr = '0; icu_biu_single = 1'b0;
        lsu_biu_rd_req = 1'b0; lsu_biu_rd_addr = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals();
        resetn = 1'b1;
        @(posedge clk); #1;

        // LSU alone, arready delayed 3 cycles
        lsu_biu_rd_addr = 32'h1000_0004;
        lsu_biu_rd_req  = 1'b1;
        push_ar(4'h1, 32'h1000_0000, 8'd0);
        @(negedge clk);
        chk("arvalid_cycle_n", arvalid, 0);
        @(posedge clk); #1;
        chk("arvalid_cycle_n1", arvalid, 1);
        ar_accept(3);
        r_beats(1'b1, 1, 64'hDEAD_BEEF_0123_4567, 2'b00, 0);
        @(negedge clk);
        chk("lsu_valid_one_cycle", biu_lsu_data_valid, 0);
        chk("idle_after_lsu", rd_busy, 0);

        // ICU line refill
        @(posedge clk); #1;
        icu_biu_addr   = 29'h0200_0003;
        icu_biu_single = 1'b0;
        icu_biu_req    = 1'b1;
        push_ar(4'h0, 32'h1000_0000, 8'd3);
        ar_accept(0);
        r_beats(1'b0, 4, 64'h1111_2222_3333_0000, 2'b00, 3);
        @(negedge clk);
        chk("idle_after_refill", rd_busy, 0);

        // Fresh reset, then both requesters together twice
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        icu_biu_single  = 1'b1;
        icu_biu_addr    = 29'h0000_0100;
        lsu_biu_rd_addr = 32'h2000_0010;
        icu_biu_req     = 1'b1;
        lsu_biu_rd_req  = 1'b1;
        push_ar(4'h1, 32'h2000_0010, 8'd0);
        push_ar(4'h0, 32'h0000_0800, 8'd0);
        ar_accept(1);
        r_beats(1'b1, 1, 64'hAAAA_0000_0000_0001, 2'b00, 0);
        ar_accept(0);
        r_beats(1'b0, 1, 64'hBBBB_0000_0000_0002, 2'b00, 0);
        icu_biu_addr    = 29'h0000_0200;
        lsu_biu_rd_addr = 32'h3000_0008;
        icu_biu_req     = 1'b1;
        lsu_biu_rd_req  = 1'b1;
        push_ar(4'h1, 32'h3000_0008, 8'd0);
        push_ar(4'h0, 32'h0000_1000, 8'd0);
        ar_accept(0);
        r_beats(1'b1, 1, 64'hCCCC_0000_0000_0003, 2'b00, 0);
        ar_accept(2);
        r_beats(1'b0, 1, 64'hDDDD_0000_0000_0004, 2'b00, 0);

        // ICU single with error response
        icu_biu_addr   = 29'h0000_0300;
        icu_biu_single = 1'b1;
        icu_biu_req    = 1'b1;
        push_ar(4'h0, 32'h0000_1800, 8'd0);
        ar_accept(0);
        r_beats(1'b0, 1, 64'hEEEE_0000_0000_0005, 2'b10, 0);
        @(negedge clk);
        chk("idle_after_fault", rd_busy, 0);

        // rvalid held during AR must not be consumed
        @(posedge clk); #1;
        lsu_biu_rd_addr = 32'h4000_0007;
        lsu_biu_rd_req  = 1'b1;
        push_ar(4'h1, 32'h4000_0000, 8'd0);
        rvalid = 1'b1;
        rlast  = 1'b1;
        rdata  = 64'hCAFE_F00D_0000_0006;
        rresp  = 2'b00;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rready_in_ar", rready, 0);
        chk("no_valid_in_ar", biu_lsu_data_valid, 0);
        @(posedge clk); #1;
        ar_accept(1);
        begin
            beat_exp_t e;
            e.lsu = 1'b1; e.data = rdata; e.last = 1'b1; e.fault = 1'b0;
            beat_q.push_back(e);
        end
        @(posedge clk); #1;
        rvalid = 1'b0;
        rlast  = 1'b0;

        // Reset in the middle of a refill, at beat 2
        icu_biu_addr   = 29'h0000_0400;
        icu_biu_single = 1'b0;
        icu_biu_req    = 1'b1;
        push_ar(4'h0, 32'h0000_2000, 8'd3);
        ar_accept(0);
        r_beats(1'b0, 1, 64'h7777_0000_0000_0000, 2'b00, 99);
        chk("busy_before_reset", rd_busy, 1);
        rvalid = 1'b1;
        rdata  = 64'h7777_0000_0000_0001;
        resetn = 1'b0;
        #1;
        check_reset_vals();
        rvalid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Fresh LSU request after the reset
        lsu_biu_rd_addr = 32'h5000_0000;
        lsu_biu_rd_req  = 1'b1;
        push_ar(4'h1, 32'h5000_0000, 8'd0);
        ar_accept(1);
        r_beats(1'b1, 1, 64'h5555_6666_7777_8888, 2'b00, 0);
        @(negedge clk);
        chk("idle_at_end", rd_busy, 0);

        chk("ar_q_drained", ar_q.size(), 0);
        chk("beat_q_drained", beat_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
